// File: rtl/blood_abnormality_monitor_if.sv
// Sample/result bundle between the acquisition front end and the abnormality monitor.
// master drives samples and clears; slave is the monitor producing results and alarms.
interface blood_abnormality_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int PH_W   = 4,
    parameter int TYPE_W = 3
);
    logic              sampleValid;
    logic [CH_W-1:0]   sampleChannel;
    logic [PH_W-1:0]   bloodPH;
    logic [TYPE_W-1:0] bloodType;
    logic [NUM_CH-1:0] clearAlarm;
    logic              resultValid;
    logic              sampleAbnormal;
    logic              channelError;
    logic [NUM_CH-1:0] typeMismatch;
    logic [NUM_CH-1:0] bloodAbnormality;

    modport master (
        output sampleValid, sampleChannel, bloodPH, bloodType, clearAlarm,
        input  resultValid, sampleAbnormal, channelError, typeMismatch, bloodAbnormality
    );

    modport slave (
        input  sampleValid, sampleChannel, bloodPH, bloodType, clearAlarm,
        output resultValid, sampleAbnormal, channelError, typeMismatch, bloodAbnormality
    );
endinterface

// File: rtl/blood_abnormality_monitor.sv
// Multi-channel blood monitor: latches each channel's blood type, flags type changes and
// raises a sticky alarm after PERSIST consecutive out-of-window pH samples.
module blood_abnormality_monitor #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int PH_W    = 4,
    parameter int TYPE_W  = 3,
    parameter int PH_LOW  = 7,
    parameter int PH_HIGH = 8,
    parameter int PERSIST = 3
) (
    input  logic clk,
    input  logic rst,
    blood_abnormality_monitor_if.slave bus
);
    localparam int CW = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {IDLE, MONITOR, ALARM} state_e;

    logic ch_ok;
    logic abn;
    logic rv_q, abn_q, cerr_q;

    assign ch_ok = {1'b0, bus.sampleChannel} < (CH_W+1)'(NUM_CH);
    assign abn   = (bus.bloodPH < PH_W'(PH_LOW)) || (bus.bloodPH > PH_W'(PH_HIGH));

    always_ff @(posedge clk) begin
        if (rst) begin
            rv_q   <= 1'b0;
            abn_q  <= 1'b0;
            cerr_q <= 1'b0;
        end else begin
            rv_q   <= bus.sampleValid && ch_ok;
            abn_q  <= bus.sampleValid && ch_ok && abn;
            cerr_q <= bus.sampleValid && !ch_ok;
        end
    end

    assign bus.resultValid    = rv_q;
    assign bus.sampleAbnormal = abn_q;
    assign bus.channelError   = cerr_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e            state_q, state_d;
        logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
        logic [TYPE_W-1:0] type_q, type_d;
        logic              alarm_q, alarm_d;
        logic              mism_q, mism_d;
        logic              hit;

        assign hit     = bus.sampleValid && (bus.sampleChannel == CH_W'(c));
        assign cnt_inc = (cnt_q == CW'(PERSIST)) ? cnt_q : cnt_q + CW'(1);

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                type_q  <= '0;
                alarm_q <= 1'b0;
                mism_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                type_q  <= type_d;
                alarm_q <= alarm_d;
                mism_q  <= mism_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            type_d  = type_q;
            alarm_d = alarm_q;
            mism_d  = mism_q;
            // A clear beats a same-cycle sample to this channel.
            if (bus.clearAlarm[c]) begin
                state_d = IDLE;
                cnt_d   = '0;
                alarm_d = 1'b0;
                mism_d  = 1'b0;
            end else if (hit) begin
                case (state_q)
                    IDLE: begin
                        type_d  = bus.bloodType;
                        cnt_d   = abn ? CW'(1) : '0;
                        state_d = MONITOR;
                        if (abn && PERSIST == 1) begin
                            alarm_d = 1'b1;
                            state_d = ALARM;
                        end
                    end
                    MONITOR: begin
                        if (bus.bloodType != type_q) begin
                            mism_d = 1'b1;
                        end else if (abn) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CW'(PERSIST)) begin
                                alarm_d = 1'b1;
                                state_d = ALARM;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    ALARM: begin
                        // Alarm is held; the run length keeps tracking for visibility.
                        if (bus.bloodType != type_q) mism_d = 1'b1;
                        else                          cnt_d  = abn ? cnt_inc : '0;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        assign bus.typeMismatch[c]     = mism_q;
        assign bus.bloodAbnormality[c] = alarm_q;
    end
endmodule
